// File: rtl/fa_pkg.sv
// Shared types and helpers for the full-adder BIST checker.
// Operands up to FA_MAXW bits are supported by fa_expect.
package fa_pkg;

    localparam int FA_MAXW = 16;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        CHECK,
        DONE
    } fa_state_e;

    typedef logic [FA_MAXW-1:0] fa_opnd_t;
    typedef logic [FA_MAXW:0]   fa_res_t;

    function automatic int nvec_bits(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int err_bits(input int w);
        return 2 * w + 2;
    endfunction

    // Zero-extended unsigned a+b+c; bits above WIDTH are always zero.
    function automatic fa_res_t fa_expect(
        input fa_opnd_t a,
        input fa_opnd_t b,
        input logic     c
    );
        return fa_res_t'(a) + fa_res_t'(b) + fa_res_t'(c);
    endfunction

endpackage

// File: rtl/fa_bist_cmp.sv
// Expected-sum generation and response mismatch flag for the BIST checker.
module fa_bist_cmp
    import fa_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic             mismatch_o
);

    fa_res_t exp_full;
    fa_res_t resp_full;

    always_comb begin
        exp_full   = fa_expect(fa_opnd_t'(a_i), fa_opnd_t'(b_i), c_i);
        resp_full  = fa_res_t'({cout_i, sum_i});
        mismatch_o = (exp_full != resp_full);
    end

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive stimulus/response BIST engine for a WIDTH-bit adder.
// Define FA_BIST_FIRSTFAIL_EN to add first-failing-vector capture outputs.
module fa_bist_checker
    import fa_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [WIDTH-1:0]             a_o,
    output logic [WIDTH-1:0]             b_o,
    output logic                         c_o,
    input  logic [WIDTH-1:0]             sum_i,
    input  logic                         cout_i,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [err_bits(WIDTH)-1:0]   err_count
`ifdef FA_BIST_FIRSTFAIL_EN
    ,
    output logic                         first_fail_valid,
    output logic [nvec_bits(WIDTH)-1:0]  first_fail_vec,
    output logic [WIDTH:0]               first_fail_resp
`endif
);

    localparam int NVEC_BITS = nvec_bits(WIDTH);
    localparam int ERR_BITS  = err_bits(WIDTH);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [NVEC_BITS-1:0] VEC_LAST = '1;
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);

    fa_state_e state_q, state_d;
    logic [NVEC_BITS-1:0] vec_q, vec_d;
    logic [NVEC_BITS-1:0] drv_q, drv_d;
    logic [SW-1:0]        set_q, set_d;
    logic [ERR_BITS-1:0]  err_q, err_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic pass_q, pass_d;
    logic mismatch;

`ifdef FA_BIST_FIRSTFAIL_EN
    logic                 ffv_q, ffv_d;
    logic [NVEC_BITS-1:0] ffvec_q, ffvec_d;
    logic [WIDTH:0]       ffresp_q, ffresp_d;
`endif

    fa_bist_cmp #(.WIDTH(WIDTH)) u_cmp (
        .a_i        (a_o),
        .b_i        (b_o),
        .c_i        (c_o),
        .sum_i      (sum_i),
        .cout_i     (cout_i),
        .mismatch_o (mismatch)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   state_d = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            SETTLE:  if (set_q == SET_LAST) state_d = CHECK;
            CHECK:   state_d = (vec_q == VEC_LAST) ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d  = vec_q;
        drv_d  = drv_q;
        set_d  = set_q;
        err_d  = err_q;
        pass_d = pass_q;
        busy_d = (state_d == APPLY) || (state_d == SETTLE) ||
                 (state_d == CHECK);
        done_d = (state_q == DONE);
`ifdef FA_BIST_FIRSTFAIL_EN
        ffv_d    = ffv_q;
        ffvec_d  = ffvec_q;
        ffresp_d = ffresp_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d  = '0;
                    err_d  = '0;
                    pass_d = 1'b0;
`ifdef FA_BIST_FIRSTFAIL_EN
                    ffv_d    = 1'b0;
                    ffvec_d  = '0;
                    ffresp_d = '0;
`endif
                end
            end
            APPLY: begin
                drv_d = vec_q;
                set_d = '0;
            end
            SETTLE: set_d = set_q + 1'b1;
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
`ifdef FA_BIST_FIRSTFAIL_EN
                    if (!ffv_q) begin
                        ffv_d    = 1'b1;
                        ffvec_d  = vec_q;
                        ffresp_d = {cout_i, sum_i};
                    end
`endif
                end
                if (vec_q != VEC_LAST) vec_d = vec_q + 1'b1;
            end
            DONE: pass_d = (err_q == '0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q  <= '0;
            drv_q  <= '0;
            set_q  <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
`ifdef FA_BIST_FIRSTFAIL_EN
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            ffresp_q <= '0;
`endif
        end else begin
            vec_q  <= vec_d;
            drv_q  <= drv_d;
            set_q  <= set_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
`ifdef FA_BIST_FIRSTFAIL_EN
            ffv_q    <= ffv_d;
            ffvec_q  <= ffvec_d;
            ffresp_q <= ffresp_d;
`endif
        end
    end

    assign a_o       = drv_q[NVEC_BITS-1 -: WIDTH];
    assign b_o       = drv_q[WIDTH -: WIDTH];
    assign c_o       = drv_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef FA_BIST_FIRSTFAIL_EN
    assign first_fail_valid = ffv_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_resp  = ffresp_q;
`endif

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: 1-bit/settle-1 and 2-bit/settle-0 builds.
// Faulty adder models are selected by the fault variable.
module tb_fa_bist_checker;

    logic clk = 1'b0;
    logic rst;
    logic start1, start2;
    logic [1:0] fault;

    logic       a1, b1, c1, sum1, cout1;
    logic       busy1, done1, pass1;
    logic [3:0] err1;
    logic [1:0] a2, b2, sum2;
    logic       c2, cout2;
    logic       busy2, done2, pass2;
    logic [5:0] err2;

`ifdef FA_BIST_FIRSTFAIL_EN
    logic       ffv1, ffv2;
    logic [2:0] ffvec1;
    logic [1:0] ffresp1;
    logic [4:0] ffvec2;
    logic [2:0] ffresp2;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // fault: 0 = correct, 1 = sum stuck-at-0, 2 = cout stuck-at-1
    always_comb begin
        {cout1, sum1} = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
        if (fault == 2'd1) sum1 = 1'b0;
        if (fault == 2'd2) cout1 = 1'b1;
        {cout2, sum2} = {1'b0, a2} + {1'b0, b2} + {2'b00, c2};
    end

    fa_bist_checker #(.WIDTH(1), .SETTLE_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a_o       (a1),
        .b_o       (b1),
        .c_o       (c1),
        .sum_i     (sum1),
        .cout_i    (cout1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1)
`ifdef FA_BIST_FIRSTFAIL_EN
        ,
        .first_fail_valid (ffv1),
        .first_fail_vec   (ffvec1),
        .first_fail_resp  (ffresp1)
`endif
    );

    fa_bist_checker #(.WIDTH(2), .SETTLE_CYCLES(0)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .a_o       (a2),
        .b_o       (b2),
        .c_o       (c2),
        .sum_i     (sum2),
        .cout_i    (cout2),
        .busy      (busy2),
        .done      (done2),
        .pass      (pass2),
        .err_count (err2)
`ifdef FA_BIST_FIRSTFAIL_EN
        ,
        .first_fail_valid (ffv2),
        .first_fail_vec   (ffvec2),
        .first_fail_resp  (ffresp2)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; k counts edges from the one sampling start.
    task automatic run(input bit w2, input int limit,
                       output int lat, output bit ord, output bit bmid);
        int per, nv;
        logic [4:0] v;
        per = w2 ? 2 : 3;
        nv  = w2 ? 32 : 8;
        lat = -1;
        ord = 1'b1;
        bmid = 1'b0;
        if (w2) start2 = 1'b1;
        else    start1 = 1'b1;
        for (int k = 0; k < limit && lat < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            start2 = 1'b0;
            v = w2 ? {a2, b2, c2} : {2'b00, a1, b1, c1};
            if (k % per == per - 1 && k / per < nv && v != 5'(k / per))
                ord = 1'b0;
            if (k == 5) bmid = w2 ? busy2 : busy1;
            if (w2 ? done2 : done1) lat = k;
        end
    endtask

    int lat, ndone, e_a, p_a, e_b, p_b;
    bit ord, bmid;

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        fault = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset1", 32'({a1, b1, c1, busy1, done1, pass1, err1}), 0);
        chk("reset2", 32'({a2, b2, c2, busy2, done2, pass2, err2}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Correct adder, full run.
        run(1'b0, 60, lat, ord, bmid);
        chk("lat_ok", lat, 25);
        chk("order_ok", 32'(ord), 1);
        chk("busy_mid", 32'(bmid), 1);
        chk("busy_at_done", 32'(busy1), 0);
        chk("pass_ok", 32'(pass1), 1);
        chk("err_ok", 32'(err1), 0);
        @(negedge clk);
        chk("done_1cyc", 32'(done1), 0);
        chk("pass_hold", 32'(pass1), 1);
        chk("vec_hold", 32'({a1, b1, c1}), 7);

        // Sum stuck-at-0.
        fault = 2'd1;
        run(1'b0, 60, lat, ord, bmid);
        chk("lat_sa0", lat, 25);
        chk("err_sa0", 32'(err1), 4);
        chk("pass_sa0", 32'(pass1), 0);
`ifdef FA_BIST_FIRSTFAIL_EN
        chk("ffv_sa0", 32'(ffv1), 1);
        chk("ffvec_sa0", 32'(ffvec1), 1);
        chk("ffresp_sa0", 32'(ffresp1), 0);
`endif

        // Cout stuck-at-1.
        fault = 2'd2;
        @(negedge clk);
        run(1'b0, 60, lat, ord, bmid);
        chk("err_sa1", 32'(err1), 4);
        chk("pass_sa1", 32'(pass1), 0);
`ifdef FA_BIST_FIRSTFAIL_EN
        chk("ffvec_sa1", 32'(ffvec1), 0);
        chk("ffresp_sa1", 32'(ffresp1), 2);
`endif

        // Reset mid-run on cycle 10.
        fault = 2'd1;
        @(negedge clk);
        start1 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
        end
        chk("err_mid", 32'(err1), 2);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_abort", 32'({a1, b1, c1, busy1, done1, pass1, err1}), 0);
`ifdef FA_BIST_FIRSTFAIL_EN
        chk("rst_ff", 32'({ffv1, ffvec1, ffresp1}), 0);
`endif
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);
        fault = 2'd0;
        run(1'b0, 60, lat, ord, bmid);
        chk("lat_after_rst", lat, 25);
        chk("pass_after_rst", 32'(pass1), 1);

        // Start held high: one done per accepted start, err cleared at restart.
        fault = 2'd1;
        @(negedge clk);
        start1 = 1'b1;
        ndone = 0;
        e_a = -1; p_a = -1; e_b = -1; p_b = -1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 30) start1 = 1'b0;
            if (done1) begin
                ndone++;
                if (ndone == 1) begin
                    e_a = 32'(err1);
                    p_a = 32'(pass1);
                    fault = 2'd0;
                    chk("held_lat1", k, 25);
                end else begin
                    e_b = 32'(err1);
                    p_b = 32'(pass1);
                    chk("held_lat2", k, 51);
`ifdef FA_BIST_FIRSTFAIL_EN
                    chk("held_ffv_clr", 32'(ffv1), 0);
`endif
                end
            end
        end
        chk("held_ndone", ndone, 2);
        chk("held_err1", e_a, 4);
        chk("held_pass1", p_a, 0);
        chk("held_err2", e_b, 0);
        chk("held_pass2", p_b, 1);

        // 2-bit adder, no settle.
        @(negedge clk);
        run(1'b1, 100, lat, ord, bmid);
        chk("w2_lat", lat, 65);
        chk("w2_order", 32'(ord), 1);
        chk("w2_pass", 32'(pass2), 1);
        chk("w2_err", 32'(err2), 0);
        chk("w2_hold", 32'({a2, b2, c2}), 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fa_bist_checker.md
Name: fa_bist_checker

Overview:
Synthesizable stimulus-and-response engine for the adder under test: it drives exhaustive operand/carry vectors into an adder and checks each {cout,sum} response.
- Acts as the on-chip driver/checker counterpart of the adder's operand/carry interface, replacing manual vector application in simulation and on board.
- Reports pass/fail, an error count and, optionally, the first failing vector.

Parameters:
- WIDTH, 1, operand width of the adder under test (1 = single full adder).
- SETTLE_CYCLES, 1, idle cycles between driving a vector and sampling the response (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- a_o  out  WIDTH  operand a to the adder.
- b_o  out  WIDTH  operand b to the adder.
- c_o  out  1  carry-in to the adder.
- sum_i  in  WIDTH  sum from the adder.
- cout_i  in  1  carry-out from the adder.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  high when the last run had zero errors; held until the next start.
- err_count  out  2*WIDTH+2  number of mismatching vectors, saturating.

Behaviour:
- Reset (already decided): one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all outputs 0 (a_o, b_o, c_o, busy, done, pass, err_count). FSM goes to IDLE and the vector counter is cleared.
- Reset mid-run aborts immediately: no done pulse, same values as above.
- Vector counter vec has 2*WIDTH+1 bits; NVEC = 2^(2*WIDTH+1).
  - Mapping: {a_o,b_o,c_o} = vec, with c_o as LSB.
  - Counts 0 to NVEC-1 in order.
- FSM states and transitions:
  - IDLE: busy=0. When start=1, clear err_count and vec, clear pass, go to APPLY.
  - APPLY: one cycle; outputs are registered from vec; busy=1. Go to SETTLE if SETTLE_CYCLES>0, else to CHECK.
  - SETTLE: wait exactly SETTLE_CYCLES cycles (settle counter), then go to CHECK.
  - CHECK: one cycle. Compare {cout_i,sum_i} with the expected value a_o+b_o+c_o computed at WIDTH+1 bits, unsigned, zero-extended. On mismatch, increment err_count, saturating at its all-ones value. If vec==NVEC-1 go to DONE; else vec+1 (no wrap is possible) and go to APPLY.
  - DONE: one cycle. done=1, busy=0, pass=(err_count==0), with this cycle's final increment already included. Then go to IDLE.
- Drive outputs (a_o, b_o, c_o) hold their last vector after the run.
- Latency: done is high exactly NVEC*(SETTLE_CYCLES+2)+1 cycles after the edge that samples start.
- start during busy or DONE is ignored; it is not queued.
- start in the same cycle as rst: rst wins.
- Inputs sum_i/cout_i are sampled only in CHECK; their values at all other times are don't-care.

Optional Feature:
- Macro FA_BIST_FIRSTFAIL_EN.
- Defined: adds outputs first_fail_valid (1), first_fail_vec (2*WIDTH+1) and first_fail_resp (WIDTH+1).
  - On the first mismatch of a run, capture vec and {cout_i,sum_i}, and set first_fail_valid.
  - These outputs are cleared on rst and on an accepted start, and hold after done.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package fa_pkg holds:
  - the state enum (IDLE, APPLY, SETTLE, CHECK, DONE);
  - localparams NVEC_BITS=2*WIDTH+1 and ERR_BITS=2*WIDTH+2, exposed as functions of WIDTH;
  - the expected-result function, which returns WIDTH+1 bits.
- One natural sub-module, fa_bist_cmp: combinational expected-sum generation and mismatch flag. The FSM, counters and capture logic stay in the top module.

Test Plan:
- WIDTH=1, SETTLE_CYCLES=1, correct full adder, start pulse → done exactly 25 cycles after the start edge, pass=1, err_count=0, and all 8 vectors applied in order 000..111.
- Same setup, sum stuck-at-0 → err_count=4 (vectors 1,2,4,7), pass=0. With FA_BIST_FIRSTFAIL_EN: first_fail_vec=3'b001, first_fail_resp=2'b00.
- Same setup, cout stuck-at-1 → err_count=4 (vectors 0,1,2,4), pass=0, first_fail_vec=3'b000.
- rst asserted on cycle 10 of a run → next cycle all outputs 0, no done pulse. A fresh start then gives a full 25-cycle run with pass=1.
- start held high through an entire run → exactly one done pulse per accepted start. A new run begins only after IDLE is re-entered, and err_count is cleared at that start.
- WIDTH=2, SETTLE_CYCLES=0, correct 2-bit ripple adder → 32 vectors, done at 65 cycles, pass=1, err_count=0.
